taxi_mac_pause_ctrl_rx: RTL and testbench
=========================================

Name: taxi_mac_pause_ctrl_rx

Overview:
Consumes the decoded MAC control frame (MCF) sideband interface from the MAC control receiver and turns it into pause state. Handles link-level flow control (LFC, 802.3x) and priority flow control (PFC, 802.1Qbb) with a configurable channel count. Keeps one quanta-based pause timer for LFC and one per PFC priority. Drives pause requests to the TX scheduler and single-cycle statistics pulses.

Parameters:
PFC_EN, 1, enable PFC decode and the per-priority timers; when 0, rx_pfc_req is tied to 0.
PFC_CH, 8, number of PFC priorities, 1..8.
QUANTA_W, 16, timer width in pause quanta.
MCF_PARAMS_SIZE, 18, width of mcf_params in bytes; must be ≥18 when PFC_EN=1 and ≥2 otherwise (elaboration-time $error).

Ports:
clk  in  1  clock
rst  in  1  reset
mcf_valid  in  1  one-cycle strobe: MCF accepted upstream
mcf_opcode  in  16  MCF opcode
mcf_params  in  MCF_PARAMS_SIZE*8  MCF parameters, byte i at bits [8i+7:8i]
cfg_rx_lfc_opcode  in  16  LFC opcode (normally 0x0001)
cfg_rx_lfc_en  in  1  honour LFC frames
cfg_rx_pfc_opcode  in  16  PFC opcode (normally 0x0101)
cfg_rx_pfc_en  in  1  honour PFC frames
quanta_tick  in  1  one pulse per elapsed pause quantum (512 bit times), generated by the MAC
rx_lfc_req  out  1  link pause active
rx_pfc_req  out  PFC_CH  per-priority pause active
rx_lfc_quanta  out  QUANTA_W  remaining LFC quanta
stat_rx_lfc_pkt  out  1  pulse: LFC frame honoured
stat_rx_lfc_xon  out  1  pulse: LFC frame with time 0
stat_rx_pfc_pkt  out  1  pulse: PFC frame honoured
stat_rx_pfc_xon  out  PFC_CH  pulse per priority loaded with time 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: every timer is 0, every request is 0, every stat output is 0.
- Input stage: mcf_valid, mcf_opcode and mcf_params are registered (stage 1). Timers update in stage 2.
- Latency: rx_*_req rises exactly 2 cycles after the mcf_valid cycle. Stat pulses are aligned with that request update.
- Frame classification in stage 1:
  - LFC hit: opcode == cfg_rx_lfc_opcode && cfg_rx_lfc_en.
  - PFC hit: PFC_EN && opcode == cfg_rx_pfc_opcode && cfg_rx_pfc_en.
  - If both opcodes match, LFC wins.
  - Any other opcode is ignored: no stat pulse, no timer change.
- Big-endian field decode:
  - LFC time = {byte0, byte1}.
  - PFC class-enable vector = byte1 (bit k = priority k); byte0 is ignored.
  - PFC time k = {byte(2+2k), byte(3+2k)}.
- Value width: values wider than QUANTA_W saturate to all-ones; narrower values are zero-extended.
- Timer channel states:
  - IDLE (count == 0): req=0.
  - PAUSED (count != 0): req=1.
- Per-channel transitions, in priority order:
  1. Enable for the channel's class deasserted → count := 0.
  2. Load event (LFC hit for the LFC timer; PFC hit with class-enable bit k set for timer k) → count := frame value. A value of 0 gives immediate XON (PAUSED→IDLE) and fires the xon stat.
  3. quanta_tick && count != 0 → count := count − 1.
  4. Otherwise hold.
- Load and tick in the same cycle: the load wins; the loaded value is not decremented that cycle.
- No wrap-around: a tick while count == 0 has no effect.
- Request timing: req is registered from the next-state (count != 0), so it drops in the same cycle count reaches 0.
- PFC frames with class-enable bit clear leave that priority's timer untouched. stat_rx_pfc_pkt still pulses if any bit in [PFC_CH-1:0] is set.
- A PFC frame with no enable bit set among [PFC_CH-1:0] is ignored, with no stat pulse.
- Back-to-back mcf_valid on consecutive cycles: each frame is processed in order, so the later load overwrites the earlier one.
- rst asserted mid-pause: all timers clear the following cycle regardless of other inputs.
- No backpressure: the block must accept mcf_valid every cycle.

Decomposition:
- Package taxi_mac_ctrl_pkg holds:
  - constants MCF_OPCODE_LFC = 16'h0001, MCF_OPCODE_PFC = 16'h0101, MCF_ETH_TYPE = 16'h8808;
  - the PFC byte-offset constants.
- Sub-module taxi_mac_pause_timer: one channel with ports clk, rst, en, load, load_val, tick, count, req. It is instantiated 1 + PFC_CH times (generate loop for PFC).

Test Plan:
- LFC time 0x0003, ticks every 4 cycles → rx_lfc_req high 2 cycles after mcf_valid, rx_lfc_quanta 3→2→1→0, req low after the third tick, stat_rx_lfc_pkt one pulse.
- LFC 0xFFFF then LFC 0x0000 three cycles later → req rises then falls 2 cycles after the second strobe; stat_rx_lfc_xon pulses once.
- PFC: byte1 = 0x05, times {0x0010, 0x0020, 0x0030,…} → rx_pfc_req = 8'h05, timer0 = 0x10, timer2 = 0x30, others stay 0; stat_rx_pfc_pkt one pulse.
- Load coincident with quanta_tick on a running timer (count 5, new value 9) → count = 9 next cycle, not 8 and not 4.
- cfg_rx_pfc_en dropped while priorities are paused → all rx_pfc_req go to 0 next cycle; subsequent PFC frames give no stat pulse.
- Unknown opcode 0x0002, then rst mid-pause → opcode 0x0002 causes no change; rst clears all req, counts and stats; PFC_CH = 4 build ignores byte1 bits [7:4].

Source files
------------

// File: rtl/taxi_mac_ctrl_pkg.sv
// Shared MAC control constants: opcodes, ethertype and the byte layout of
// the pause-frame parameter field.
package taxi_mac_ctrl_pkg;

  localparam logic [15:0] MCF_OPCODE_LFC = 16'h0001;
  localparam logic [15:0] MCF_OPCODE_PFC = 16'h0101;
  localparam logic [15:0] MCF_ETH_TYPE   = 16'h8808;

  localparam int LFC_TIME_BYTE  = 0;
  localparam int PFC_CEV_BYTE   = 1;
  localparam int PFC_TIME_BYTE0 = 2;

  localparam int LFC_MIN_PARAMS = 2;
  localparam int PFC_MIN_PARAMS = 18;

  // First (most significant) byte of the big-endian pause time for priority k
  function automatic int pfc_time_byte(input int k);
    return PFC_TIME_BYTE0 + 2 * k;
  endfunction

endpackage

// File: rtl/taxi_mac_pause_timer.sv
// One pause channel: a quanta down-counter with a registered request that
// is high while the counter is non-zero.
module taxi_mac_pause_timer #(
  parameter int QUANTA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [QUANTA_W-1:0] load_val,
  input  logic                tick,
  output logic [QUANTA_W-1:0] count,
  output logic                req
);

  logic [QUANTA_W-1:0] count_q, count_d;
  logic                req_q, req_d;

  // Disable beats load, load beats tick, and an idle counter never wraps
  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - QUANTA_W'(1);
    end
    req_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  assign count = count_q;
  assign req   = req_q;

endmodule

// File: rtl/taxi_mac_pause_ctrl_rx.sv
// Receive-side pause control: decodes LFC/PFC control frames from the MCF
// sideband and runs the link and per-priority pause timers.
module taxi_mac_pause_ctrl_rx
  import taxi_mac_ctrl_pkg::*;
#(
  parameter int PFC_EN          = 1,
  parameter int PFC_CH          = 8,
  parameter int QUANTA_W        = 16,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mcf_valid,
  input  logic [15:0]                  mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  input  logic [15:0]                  cfg_rx_lfc_opcode,
  input  logic                         cfg_rx_lfc_en,
  input  logic [15:0]                  cfg_rx_pfc_opcode,
  input  logic                         cfg_rx_pfc_en,
  input  logic                         quanta_tick,
  output logic                         rx_lfc_req,
  output logic [PFC_CH-1:0]            rx_pfc_req,
  output logic [QUANTA_W-1:0]          rx_lfc_quanta,
  output logic                         stat_rx_lfc_pkt,
  output logic                         stat_rx_lfc_xon,
  output logic                         stat_rx_pfc_pkt,
  output logic [PFC_CH-1:0]            stat_rx_pfc_xon
);

  localparam int PW = MCF_PARAMS_SIZE * 8;

  if (PFC_EN != 0 && MCF_PARAMS_SIZE < PFC_MIN_PARAMS) begin : g_chk_pfc_size
    $error("MCF_PARAMS_SIZE too small for PFC decode");
  end
  if (MCF_PARAMS_SIZE < LFC_MIN_PARAMS) begin : g_chk_lfc_size
    $error("MCF_PARAMS_SIZE too small for LFC decode");
  end
  if (PFC_CH < 1 || PFC_CH > 8) begin : g_chk_pfc_ch
    $error("PFC_CH must be 1..8");
  end

  function automatic logic [QUANTA_W-1:0] sat_quanta(input logic [15:0] v);
    logic [31:0] wide;
    wide = {16'd0, v};
    if ((wide >> QUANTA_W) != 32'd0) return {QUANTA_W{1'b1}};
    return QUANTA_W'(wide);
  endfunction

  // Stage 1: register the MCF sideband
  logic          vld_p1_q, vld_p1_d;
  logic [15:0]   opcode_p1_q, opcode_p1_d;
  logic [PW-1:0] params_p1_q, params_p1_d;

  always_comb begin
    vld_p1_d    = mcf_valid;
    opcode_p1_d = mcf_opcode;
    params_p1_d = mcf_params;
  end

  always_ff @(posedge clk) begin
    opcode_p1_q <= opcode_p1_d;
    params_p1_q <= params_p1_d;
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  logic              lfc_hit, pfc_hit, pfc_load_any;
  logic [15:0]       lfc_time;
  logic [PFC_CH-1:0] pfc_cev;

  // LFC takes precedence when both configured opcodes match the frame
  always_comb begin
    lfc_hit      = vld_p1_q && (opcode_p1_q == cfg_rx_lfc_opcode) && cfg_rx_lfc_en;
    pfc_hit      = (PFC_EN != 0) && vld_p1_q && (opcode_p1_q == cfg_rx_pfc_opcode)
                   && cfg_rx_pfc_en && !lfc_hit;
    lfc_time     = {params_p1_q[8*LFC_TIME_BYTE +: 8], params_p1_q[8*(LFC_TIME_BYTE+1) +: 8]};
    pfc_cev      = params_p1_q[8*PFC_CEV_BYTE +: PFC_CH];
    pfc_load_any = pfc_hit && (pfc_cev != '0);
  end

  // Stage 2: timers and statistics
  logic                             stat_lfc_pkt_q, stat_lfc_pkt_d;
  logic                             stat_lfc_xon_q, stat_lfc_xon_d;
  logic                             stat_pfc_pkt_q, stat_pfc_pkt_d;
  logic [PFC_CH-1:0]                stat_pfc_xon_q, stat_pfc_xon_d;
  logic [PFC_CH-1:0][QUANTA_W-1:0]  pfc_count;
  logic [QUANTA_W-1:0]              lfc_load_val;

  always_comb begin
    stat_lfc_pkt_d = lfc_hit;
    stat_lfc_xon_d = lfc_hit && (lfc_time == 16'd0);
    stat_pfc_pkt_d = pfc_load_any;
    lfc_load_val   = sat_quanta(lfc_time);
  end

  taxi_mac_pause_timer #(.QUANTA_W(QUANTA_W)) u_lfc_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (cfg_rx_lfc_en),
    .load     (lfc_hit),
    .load_val (lfc_load_val),
    .tick     (quanta_tick),
    .count    (rx_lfc_quanta),
    .req      (rx_lfc_req)
  );

  if (PFC_EN != 0) begin : g_pfc
    for (genvar k = 0; k < PFC_CH; k++) begin : g_ch
      localparam int TB = pfc_time_byte(k);
      logic [15:0]         pfc_time;
      logic                pfc_load;
      logic [QUANTA_W-1:0] pfc_load_val;

      assign pfc_time          = {params_p1_q[8*TB +: 8], params_p1_q[8*(TB+1) +: 8]};
      assign pfc_load          = pfc_hit && pfc_cev[k];
      assign pfc_load_val      = sat_quanta(pfc_time);
      assign stat_pfc_xon_d[k] = pfc_load && (pfc_time == 16'd0);

      taxi_mac_pause_timer #(.QUANTA_W(QUANTA_W)) u_pfc_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (cfg_rx_pfc_en),
        .load     (pfc_load),
        .load_val (pfc_load_val),
        .tick     (quanta_tick),
        .count    (pfc_count[k]),
        .req      (rx_pfc_req[k])
      );
    end
  end else begin : g_no_pfc
    assign rx_pfc_req     = '0;
    assign stat_pfc_xon_d = '0;
    assign pfc_count      = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lfc_pkt_q <= 1'b0;
      stat_lfc_xon_q <= 1'b0;
      stat_pfc_pkt_q <= 1'b0;
      stat_pfc_xon_q <= '0;
    end else begin
      stat_lfc_pkt_q <= stat_lfc_pkt_d;
      stat_lfc_xon_q <= stat_lfc_xon_d;
      stat_pfc_pkt_q <= stat_pfc_pkt_d;
      stat_pfc_xon_q <= stat_pfc_xon_d;
    end
  end

  assign stat_rx_lfc_pkt = stat_lfc_pkt_q;
  assign stat_rx_lfc_xon = stat_lfc_xon_q;
  assign stat_rx_pfc_pkt = stat_pfc_pkt_q;
  assign stat_rx_pfc_xon = stat_pfc_xon_q;

  // Parameter bytes beyond the decoded fields and the PFC counts have no consumer
  logic unused_p1;
  assign unused_p1 = ^{params_p1_q, pfc_count, pfc_hit};

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_rx.sv
// Bench for taxi_mac_pause_ctrl_rx: an 8-priority/16-bit build and a
// 4-priority/8-bit build share stimulus and are checked every cycle.
module tb_taxi_mac_pause_ctrl_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mcf_valid, cfg_rx_lfc_en, cfg_rx_pfc_en, quanta_tick;
  logic [15:0]  mcf_opcode, cfg_rx_lfc_opcode, cfg_rx_pfc_opcode;
  logic [143:0] mcf_params;

  logic        a_lfc_req, a_lfc_pkt, a_lfc_xon, a_pfc_pkt;
  logic [7:0]  a_pfc_req, a_pfc_xon;
  logic [15:0] a_quanta;
  logic        b_lfc_req, b_lfc_pkt, b_lfc_xon, b_pfc_pkt;
  logic [3:0]  b_pfc_req, b_pfc_xon;
  logic [7:0]  b_quanta;

  taxi_mac_pause_ctrl_rx #(.PFC_EN(1), .PFC_CH(8), .QUANTA_W(16), .MCF_PARAMS_SIZE(18)) dut_a (
    .clk(clk), .rst(rst), .mcf_valid(mcf_valid), .mcf_opcode(mcf_opcode), .mcf_params(mcf_params),
    .cfg_rx_lfc_opcode(cfg_rx_lfc_opcode), .cfg_rx_lfc_en(cfg_rx_lfc_en),
    .cfg_rx_pfc_opcode(cfg_rx_pfc_opcode), .cfg_rx_pfc_en(cfg_rx_pfc_en),
    .quanta_tick(quanta_tick), .rx_lfc_req(a_lfc_req), .rx_pfc_req(a_pfc_req),
    .rx_lfc_quanta(a_quanta), .stat_rx_lfc_pkt(a_lfc_pkt), .stat_rx_lfc_xon(a_lfc_xon),
    .stat_rx_pfc_pkt(a_pfc_pkt), .stat_rx_pfc_xon(a_pfc_xon)
  );

  taxi_mac_pause_ctrl_rx #(.PFC_EN(1), .PFC_CH(4), .QUANTA_W(8), .MCF_PARAMS_SIZE(18)) dut_b (
    .clk(clk), .rst(rst), .mcf_valid(mcf_valid), .mcf_opcode(mcf_opcode), .mcf_params(mcf_params),
    .cfg_rx_lfc_opcode(cfg_rx_lfc_opcode), .cfg_rx_lfc_en(cfg_rx_lfc_en),
    .cfg_rx_pfc_opcode(cfg_rx_pfc_opcode), .cfg_rx_pfc_en(cfg_rx_pfc_en),
    .quanta_tick(quanta_tick), .rx_lfc_req(b_lfc_req), .rx_pfc_req(b_pfc_req),
    .rx_lfc_quanta(b_quanta), .stat_rx_lfc_pkt(b_lfc_pkt), .stat_rx_lfc_xon(b_lfc_xon),
    .stat_rx_pfc_pkt(b_pfc_pkt), .stat_rx_pfc_xon(b_pfc_xon)
  );

  // Reference state: remaining quanta per channel and expected stat pulses
  int           ch [2] = '{8, 4};
  int           qw [2] = '{16, 8};
  int           m_lfc [2];
  int           m_pfc [2][8];
  bit           m_lpkt [2], m_lxon [2], m_ppkt [2];
  bit [7:0]     m_pxon [2];
  bit           pv;
  logic [15:0]  pop;
  logic [143:0] pp;
  int           n_chk = 0, n_pass = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [143:0] lfc_p(input logic [15:0] t);
    logic [143:0] p;
    p = '0;
    p[7:0]  = t[15:8];
    p[15:8] = t[7:0];
    return p;
  endfunction

  function automatic logic [143:0] pfc_p(input logic [7:0] cev, input int base, input int inc);
    logic [143:0] p;
    logic [15:0]  t;
    p = '0;
    p[15:8] = cev;
    for (int k = 0; k < 8; k++) begin
      t = 16'(base + inc * k);
      p[8*(2+2*k) +: 8] = t[15:8];
      p[8*(3+2*k) +: 8] = t[7:0];
    end
    return p;
  endfunction

  // Applies the frame seen in the previous cycle plus this cycle's tick/enables
  task automatic model_edge();
    bit          lhit, phit;
    bit [7:0]    cev;
    int          lt, pt;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_lfc[d] = 0;
        for (int k = 0; k < 8; k++) m_pfc[d][k] = 0;
        m_lpkt[d] = 0; m_lxon[d] = 0; m_ppkt[d] = 0; m_pxon[d] = '0;
      end else begin
        lhit = pv && (pop == cfg_rx_lfc_opcode) && cfg_rx_lfc_en;
        phit = pv && (pop == cfg_rx_pfc_opcode) && cfg_rx_pfc_en && !lhit;
        cev  = pp[15:8] & 8'((1 << ch[d]) - 1);
        lt   = {pp[7:0], pp[15:8]};
        m_lpkt[d] = lhit;
        m_lxon[d] = lhit && (lt == 0);
        m_ppkt[d] = phit && (cev != 0);
        m_pxon[d] = '0;
        if (!cfg_rx_lfc_en) m_lfc[d] = 0;
        else if (lhit) m_lfc[d] = sat(lt, qw[d]);
        else if (quanta_tick && m_lfc[d] > 0) m_lfc[d] = m_lfc[d] - 1;
        for (int k = 0; k < ch[d]; k++) begin
          pt = {pp[8*(2+2*k) +: 8], pp[8*(3+2*k) +: 8]};
          if (!cfg_rx_pfc_en) m_pfc[d][k] = 0;
          else if (phit && cev[k]) begin
            m_pfc[d][k] = sat(pt, qw[d]);
            m_pxon[d][k] = (pt == 0);
          end else if (quanta_tick && m_pfc[d][k] > 0) m_pfc[d][k] = m_pfc[d][k] - 1;
        end
      end
    end
    pv  = rst ? 1'b0 : mcf_valid;
    pop = mcf_opcode;
    pp  = mcf_params;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare();
    bit [7:0] rq [2];
    for (int d = 0; d < 2; d++) begin
      rq[d] = '0;
      for (int k = 0; k < ch[d]; k++) rq[d][k] = (m_pfc[d][k] != 0);
    end
    chk("a_lfc_req",    32'(a_lfc_req), 32'(m_lfc[0] != 0));
    chk("a_lfc_quanta", 32'(a_quanta),  32'(m_lfc[0]));
    chk("a_pfc_req",    32'(a_pfc_req), 32'(rq[0]));
    chk("a_lfc_pkt",    32'(a_lfc_pkt), 32'(m_lpkt[0]));
    chk("a_lfc_xon",    32'(a_lfc_xon), 32'(m_lxon[0]));
    chk("a_pfc_pkt",    32'(a_pfc_pkt), 32'(m_ppkt[0]));
    chk("a_pfc_xon",    32'(a_pfc_xon), 32'(m_pxon[0]));
    chk("b_lfc_req",    32'(b_lfc_req), 32'(m_lfc[1] != 0));
    chk("b_lfc_quanta", 32'(b_quanta),  32'(m_lfc[1]));
    chk("b_pfc_req",    32'(b_pfc_req), 32'(rq[1][3:0]));
    chk("b_lfc_pkt",    32'(b_lfc_pkt), 32'(m_lpkt[1]));
    chk("b_pfc_pkt",    32'(b_pfc_pkt), 32'(m_ppkt[1]));
    chk("b_pfc_xon",    32'(b_pfc_xon), 32'(m_pxon[1][3:0]));
  endtask

  task automatic cyc(input bit v, input logic [15:0] op, input logic [143:0] p, input bit t);
    mcf_valid = v; mcf_opcode = op; mcf_params = p; quanta_tick = t;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n, input int tick_every);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 16'h0000, '0, (tick_every > 0) && ((i % tick_every) == tick_every - 1));
  endtask

  logic [143:0] rp;
  int           r;

  initial begin
    rst = 1'b1; mcf_valid = 1'b0; mcf_opcode = '0; mcf_params = '0; quanta_tick = 1'b0;
    cfg_rx_lfc_opcode = 16'h0001; cfg_rx_pfc_opcode = 16'h0101;
    cfg_rx_lfc_en = 1'b1; cfg_rx_pfc_en = 1'b1;
    pv = 0; pop = '0; pp = '0;
    idle(2, 0);
    chk("rst_lfc_req", 32'(a_lfc_req), 32'd0);
    chk("rst_quanta",  32'(a_quanta),  32'd0);
    chk("rst_pfc_req", 32'(a_pfc_req), 32'd0);
    rst = 1'b0;
    idle(1, 0);

    // LFC 3 quanta, tick every 4 cycles
    cyc(1'b1, 16'h0001, lfc_p(16'h0003), 1'b0);
    chk("lfc_latency_low", 32'(a_lfc_req), 32'd0);
    idle(1, 0);
    chk("lfc_rise",   32'(a_lfc_req), 32'd1);
    chk("lfc_q3",     32'(a_quanta),  32'd3);
    chk("lfc_pkt",    32'(a_lfc_pkt), 32'd1);
    idle(12, 4);
    chk("lfc_expire", 32'(a_lfc_req), 32'd0);
    chk("lfc_q0",     32'(a_quanta),  32'd0);

    // LFC 0xFFFF then XON three cycles later
    cyc(1'b1, 16'h0001, lfc_p(16'hFFFF), 1'b0);
    idle(2, 0);
    cyc(1'b1, 16'h0001, lfc_p(16'h0000), 1'b0);
    chk("xon_still_paused", 32'(a_lfc_req), 32'd1);
    chk("b_sat_ff",         32'(b_quanta),  32'hFF);
    idle(1, 0);
    chk("xon_drop",  32'(a_lfc_req), 32'd0);
    chk("xon_stat",  32'(a_lfc_xon), 32'd1);

    // PFC enable 0x05, times 0x10,0x20,0x30...
    cyc(1'b1, 16'h0101, pfc_p(8'h05, 16'h10, 16'h10), 1'b0);
    idle(1, 0);
    chk("pfc_req05", 32'(a_pfc_req), 32'h05);
    chk("pfc_pkt",   32'(a_pfc_pkt), 32'd1);
    idle(60, 1);
    chk("pfc_done",  32'(a_pfc_req), 32'h00);

    // Load coincident with tick: 5 running, load 9
    cyc(1'b1, 16'h0001, lfc_p(16'd5), 1'b0);
    idle(1, 0);
    chk("load_q5", 32'(a_quanta), 32'd5);
    cyc(1'b1, 16'h0001, lfc_p(16'd9), 1'b0);
    cyc(1'b0, 16'h0000, '0, 1'b1);
    chk("load_wins_tick", 32'(a_quanta), 32'd9);

    // PFC enable dropped while paused
    cyc(1'b1, 16'h0101, pfc_p(8'hFF, 16'h20, 1), 1'b0);
    idle(1, 0);
    chk("pfc_all_paused", 32'(a_pfc_req), 32'hFF);
    cfg_rx_pfc_en = 1'b0;
    idle(1, 0);
    chk("pfc_dis_clear", 32'(a_pfc_req), 32'h00);
    cyc(1'b1, 16'h0101, pfc_p(8'hFF, 16'h20, 1), 1'b0);
    idle(1, 0);
    chk("pfc_dis_nostat", 32'(a_pfc_pkt), 32'd0);
    cfg_rx_pfc_en = 1'b1;

    // Saturation, unknown opcode, high-only class bits on the 4-priority build, reset mid-pause
    cyc(1'b1, 16'h0001, lfc_p(16'h1234), 1'b0);
    idle(1, 0);
    chk("a_q1234", 32'(a_quanta), 32'h1234);
    chk("b_qsat",  32'(b_quanta), 32'hFF);
    cyc(1'b1, 16'h0002, lfc_p(16'h0007), 1'b0);
    idle(1, 0);
    chk("unk_hold",   32'(a_quanta),  32'h1234);
    chk("unk_nostat", 32'(a_lfc_pkt), 32'd0);
    cyc(1'b1, 16'h0101, pfc_p(8'hF0, 16'h8, 0), 1'b0);
    idle(1, 0);
    chk("b_hi_cev_ignored", 32'(b_pfc_pkt), 32'd0);
    chk("a_hi_cev_req",     32'(a_pfc_req), 32'hF0);
    rst = 1'b1;
    cyc(1'b1, 16'h0001, lfc_p(16'h0050), 1'b1);
    chk("rst_mid_lfc", 32'(a_lfc_req), 32'd0);
    chk("rst_mid_pfc", 32'(a_pfc_req), 32'd0);
    chk("rst_mid_q",   32'(a_quanta),  32'd0);
    rst = 1'b0;
    idle(2, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 18; b++) rp[8*b +: 8] = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 8; k++) begin
          rp[8*(2+2*k) +: 8] = 8'h00;
          rp[8*(3+2*k) +: 8] = 8'($urandom_range(0, 6));
        end
      if ($urandom_range(0, 1) == 1) rp[7:0] = 8'h00;
      if ($urandom_range(0, 99) < 3) cfg_rx_lfc_en = ~cfg_rx_lfc_en;
      if ($urandom_range(0, 99) < 3) cfg_rx_pfc_en = ~cfg_rx_pfc_en;
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      cyc($urandom_range(0, 99) < 35,
          (r < 4) ? 16'h0001 : (r < 8) ? 16'h0101 : (r == 8) ? 16'h0002 : 16'($urandom),
          rp, $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    idle(4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
